ahb_decode_ctrl: RTL and testbench

AHB-Lite address decoder and data-phase select controller for the three-slave read-return multiplexer. It decodes the address phase into one-hot hsel outputs and registers a 2-bit data-phase select that steers the read mux. It contains a built-in default slave that gives the two-cycle AHB ERROR response to unmapped transfers. The block sits between the master's address/control bus and the slave hsel inputs and read-mux select.

---
 rtl/ahb_pkg.sv | 36 +++
 rtl/ahb_default_slave.sv | 79 +++++++
 rtl/ahb_decode_ctrl.sv | 77 +++++++
 tb/tb_ahb_decode_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the decoder / default-slave slice:
// transfer-type and response encodings, read-mux select codes, the
// default-slave state type and the address-match helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Read-mux select codes; SEL_DEF routes the built-in default slave.
  typedef enum logic [1:0] {
    SEL_S1  = 2'b00,
    SEL_S2  = 2'b01,
    SEL_S3  = 2'b10,
    SEL_DEF = 2'b11
  } sel_code_t;

  // Default-slave ERROR-response states.
  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } def_state_t;

  // True when the masked address equals the region base.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in AHB-Lite default slave: answers accepted unmapped NONSEQ/SEQ
// transfers with the two-cycle ERROR response (wait state, then
// ERROR with hreadyout high). When ERR_CAPTURE_EN is defined it also
// records the faulting address in a sticky error register.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        i_err_req,     // accepted unmapped NONSEQ/SEQ this cycle
`ifdef ERR_CAPTURE_EN
  input  logic [31:0] haddr,
  input  logic        err_clr,
  output logic [31:0] err_addr,
  output logic        err_valid,
`endif
  output logic        def_hreadyout,
  output logic        def_hresp
);

  def_state_t r_state;
  def_state_t w_next;

  // State register for the ERROR-response FSM.
  // NOTE: asynchronous reset sits in the sensitivity list so the FSM drops to IDLE without a clock; state uses non-blocking assignment.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= DS_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and Moore outputs of the default slave.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_next        = r_state;
    def_hreadyout = 1'b1;
    def_hresp     = HRESP_OKAY;
    case (r_state)
      DS_IDLE: begin
        if (i_err_req) w_next = DS_ERR1;
      end
      DS_ERR1: begin
        def_hreadyout = 1'b0;
        def_hresp     = HRESP_ERROR;
        w_next        = DS_ERR2;
      end
      DS_ERR2: begin
        def_hresp = HRESP_ERROR;
        w_next    = i_err_req ? DS_ERR1 : DS_IDLE;
      end
      default: w_next = DS_IDLE;
    endcase
  end

`ifdef ERR_CAPTURE_EN
  logic [31:0] r_err_addr;
  logic        r_err_valid;
  logic        w_err_set;

  // A fault is captured exactly on the IDLE/ERR2 -> ERR1 transition.
  assign w_err_set = i_err_req && (r_state != DS_ERR1);

  // Sticky fault capture; a set in the same cycle as a clear wins.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_err_addr  <= '0;
      r_err_valid <= 1'b0;
    end else if (w_err_set) begin
      r_err_addr  <= haddr;
      r_err_valid <= 1'b1;
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
    end
  end

  assign err_addr  = r_err_addr;
  assign err_valid = r_err_valid;
`endif

endmodule

// File: rtl/ahb_decode_ctrl.sv
// AHB-Lite three-slave address decoder with registered data-phase read-mux
// select and a built-in default slave for unmapped addresses.
// Optional build macro: ERR_CAPTURE_EN adds the err_addr / err_valid /
// err_clr faulting-address capture.
module ahb_decode_ctrl
  import ahb_pkg::*;
#(
  parameter logic [31:0] S1_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000,
  parameter logic [31:0] S2_BASE = 32'h1000_0000,
  parameter logic [31:0] S2_MASK = 32'hF000_0000,
  parameter logic [31:0] S3_BASE = 32'h2000_0000,
  parameter logic [31:0] S3_MASK = 32'hF000_0000
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hready,
  output logic        hsel_1,
  output logic        hsel_2,
  output logic        hsel_3,
  output logic [1:0]  sel,
  output logic        def_hreadyout,
  output logic        def_hresp,
`ifdef ERR_CAPTURE_EN
  output logic [31:0] err_addr,
  output logic        err_valid,
  input  logic        err_clr,
`endif
  output logic        o_unused_tie    // constant-low tie-off output
);

  sel_code_t w_code;
  sel_code_t r_sel;
  logic      w_active;
  logic      w_err_req;

  // Priority address decode S1 > S2 > S3; no hit selects the default slave.
  always_comb begin
    w_code = SEL_DEF;
    if      (addr_hit(haddr, S1_BASE, S1_MASK)) w_code = SEL_S1;
    else if (addr_hit(haddr, S2_BASE, S2_MASK)) w_code = SEL_S2;
    else if (addr_hit(haddr, S3_BASE, S3_MASK)) w_code = SEL_S3;
  end

  assign hsel_1 = (w_code == SEL_S1);
  assign hsel_2 = (w_code == SEL_S2);
  assign hsel_3 = (w_code == SEL_S3);

  // Data-phase select follows whichever slave owns the accepted address phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)    r_sel <= SEL_S1;
    else if (hready) r_sel <= w_code;
  end

  assign sel          = r_sel;
  assign o_unused_tie = 1'b0;

  assign w_active  = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign w_err_req = hready && w_active && (w_code == SEL_DEF);

  ahb_default_slave u_def_slave (
    .hclk          (hclk),
    .hresetn       (hresetn),
    .i_err_req     (w_err_req),
`ifdef ERR_CAPTURE_EN
    .haddr         (haddr),
    .err_clr       (err_clr),
    .err_addr      (err_addr),
    .err_valid     (err_valid),
`endif
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp)
  );

endmodule

// File: tb/tb_ahb_decode_ctrl.sv
// Self-checking bench for ahb_decode_ctrl: directed vector table, hand-written
// reset / capture sequences, then randomized traffic against a reference model.
module tb_ahb_decode_ctrl;

  logic        hclk;
  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        err_clr;
  logic        hsel_1, hsel_2, hsel_3;
  logic [1:0]  sel;
  logic        def_hreadyout, def_hresp;
  logic        unused_tie;
`ifdef ERR_CAPTURE_EN
  logic [31:0] err_addr;
  logic        err_valid;
`endif

  int vectors;
  int miscompares;

  ahb_decode_ctrl dut (
    .hclk          (hclk),
    .hresetn       (hresetn),
    .haddr         (haddr),
    .htrans        (htrans),
    .hready        (hready),
    .hsel_1        (hsel_1),
    .hsel_2        (hsel_2),
    .hsel_3        (hsel_3),
    .sel           (sel),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp),
`ifdef ERR_CAPTURE_EN
    .err_addr      (err_addr),
    .err_valid     (err_valid),
    .err_clr       (err_clr),
`endif
    .o_unused_tie  (unused_tie)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // ---------------- reference model ----------------
  logic [31:0] reg_base [3] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
  logic [31:0] reg_mask [3] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic [1:0]  m_sel;
  int          m_err_left;   // data-phase cycles of ERROR response still to come
  logic        m_err_valid;
  logic [31:0] m_err_addr;

  // Index of the first matching region, 3 when nothing matches.
  function automatic logic [1:0] ref_decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & reg_mask[i]) == reg_base[i]) return 2'(i);
    return 2'd3;
  endfunction

  function automatic logic [2:0] ref_hsel(input logic [31:0] a);
    logic [1:0] c;
    c = ref_decode(a);
    return (c == 2'd3) ? 3'b000 : 3'(1 << c);
  endfunction

  task automatic model_reset();
    m_sel       = 2'b00;
    m_err_left  = 0;
    m_err_valid = 1'b0;
    m_err_addr  = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    logic [1:0] code;
    logic       fault;
    logic       entering;
    code     = ref_decode(haddr);
    fault    = hready && htrans[1] && (code == 2'd3);
    entering = fault && (m_err_left != 2);
    if (m_err_left == 2) m_err_left = 1;
    else                 m_err_left = fault ? 2 : 0;
    if (hready) m_sel = code;
    if (entering) begin
      m_err_valid = 1'b1;
      m_err_addr  = haddr;
    end else if (err_clr) begin
      m_err_valid = 1'b0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r, input logic c);
    haddr   = a;
    htrans  = t;
    hready  = r;
    err_clr = c;
  endtask

  // Clock edge: the model follows the same inputs; inputs change #1 later.
  task automatic tick();
    @(posedge hclk);
    if (!hresetn) model_reset();
    else          model_clock();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_hsel"}, 32'({hsel_3, hsel_2, hsel_1}), 32'(ref_hsel(haddr)));
    check({tag, "_sel"},  32'(sel), 32'(m_sel));
    check({tag, "_rdy"},  32'(def_hreadyout), 32'(m_err_left != 2));
    check({tag, "_resp"}, 32'(def_hresp), 32'(m_err_left != 0));
`ifdef ERR_CAPTURE_EN
    check({tag, "_evld"}, 32'(err_valid), 32'(m_err_valid));
    if (m_err_valid) check({tag, "_eaddr"}, err_addr, m_err_addr);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic        r;
    logic [2:0]  e_hsel;
    logic [1:0]  e_sel;
    logic        e_rdy;
    logic        e_resp;
  } vec_t;

  vec_t tbl [23];

  initial begin
    tbl[0]  = '{32'h1000_0040, 2'b10, 1'b1, 3'b010, 2'b00, 1'b1, 1'b0};
    tbl[1]  = '{32'h1000_0040, 2'b00, 1'b0, 3'b010, 2'b01, 1'b1, 1'b0};
    tbl[2]  = '{32'h0000_0000, 2'b10, 1'b0, 3'b001, 2'b01, 1'b1, 1'b0};
    tbl[3]  = '{32'h0000_0000, 2'b10, 1'b0, 3'b001, 2'b01, 1'b1, 1'b0};
    tbl[4]  = '{32'h2000_0000, 2'b00, 1'b1, 3'b100, 2'b01, 1'b1, 1'b0};
    tbl[5]  = '{32'h8000_0000, 2'b10, 1'b1, 3'b000, 2'b10, 1'b1, 1'b0};
    tbl[6]  = '{32'h8000_0000, 2'b00, 1'b0, 3'b000, 2'b11, 1'b0, 1'b1};
    tbl[7]  = '{32'h0000_0000, 2'b00, 1'b1, 3'b001, 2'b11, 1'b1, 1'b1};
    tbl[8]  = '{32'h0000_0000, 2'b00, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{32'h8000_0000, 2'b10, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{32'h8000_0000, 2'b00, 1'b0, 3'b000, 2'b11, 1'b0, 1'b1};
    tbl[11] = '{32'h9000_0000, 2'b11, 1'b1, 3'b000, 2'b11, 1'b1, 1'b1};
    tbl[12] = '{32'h0000_0000, 2'b00, 1'b0, 3'b001, 2'b11, 1'b0, 1'b1};
    tbl[13] = '{32'h0000_0000, 2'b00, 1'b1, 3'b001, 2'b11, 1'b1, 1'b1};
    tbl[14] = '{32'h0000_0000, 2'b00, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0};
    tbl[15] = '{32'h8000_0000, 2'b00, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0};
    tbl[16] = '{32'h8000_0000, 2'b01, 1'b1, 3'b000, 2'b11, 1'b1, 1'b0};
    tbl[17] = '{32'h0000_0000, 2'b00, 1'b1, 3'b001, 2'b11, 1'b1, 1'b0};
    tbl[18] = '{32'h0000_0000, 2'b00, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0};
    tbl[19] = '{32'h2FFF_FFFF, 2'b10, 1'b1, 3'b100, 2'b00, 1'b1, 1'b0};
    tbl[20] = '{32'h3000_0000, 2'b00, 1'b1, 3'b000, 2'b10, 1'b1, 1'b0};
    tbl[21] = '{32'h0FFF_FFFC, 2'b00, 1'b1, 3'b001, 2'b11, 1'b1, 1'b0};
    tbl[22] = '{32'h1FFF_FFFF, 2'b00, 1'b1, 3'b010, 2'b00, 1'b1, 1'b0};
  end

  task automatic do_reset();
    hresetn = 1'b0;
    drive(32'h0, 2'b00, 1'b1, 1'b0);
    model_reset();
    repeat (2) tick();
    hresetn = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    hresetn     = 1'b0;
    drive(32'h0, 2'b00, 1'b1, 1'b0);
    #2;
    check("rst_sel",  32'(sel), 32'h0);
    check("rst_rdy",  32'(def_hreadyout), 32'h1);
    check("rst_resp", 32'(def_hresp), 32'h0);
    check("rst_tie",  32'(unused_tie), 32'h0);
    do_reset();

    // Directed table.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].a, tbl[i].t, tbl[i].r, 1'b0);
      @(negedge hclk);
      check($sformatf("tbl%0d_hsel", i), 32'({hsel_3, hsel_2, hsel_1}), 32'(tbl[i].e_hsel));
      check($sformatf("tbl%0d_sel", i),  32'(sel), 32'(tbl[i].e_sel));
      check($sformatf("tbl%0d_rdy", i),  32'(def_hreadyout), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_resp", i), 32'(def_hresp), 32'(tbl[i].e_resp));
      tick();
    end

    // Asynchronous reset in the middle of an ERROR response.
    do_reset();
    drive(32'h8000_0000, 2'b10, 1'b1, 1'b0);
    tick();
    drive(32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    check("pre_rst_resp", 32'(def_hresp), 32'h1);
    check("pre_rst_rdy",  32'(def_hreadyout), 32'h0);
    hresetn = 1'b0;
    #1;
    check("midrst_sel",  32'(sel), 32'h0);
    check("midrst_rdy",  32'(def_hreadyout), 32'h1);
    check("midrst_resp", 32'(def_hresp), 32'h0);
    model_reset();
    tick();
    hresetn = 1'b1;

`ifdef ERR_CAPTURE_EN
    // Fault capture, set-beats-clear, clear alone.
    drive(32'hDEAD_0000, 2'b10, 1'b1, 1'b0);
    tick();
    drive(32'h0, 2'b00, 1'b0, 1'b0);
    @(negedge hclk);
    check("cap_valid", 32'(err_valid), 32'h1);
    check("cap_addr",  err_addr, 32'hDEAD_0000);
    tick();                                          // now ERR2
    drive(32'hBEEF_0000, 2'b10, 1'b1, 1'b1);         // new fault + clear
    tick();
    drive(32'h0, 2'b00, 1'b0, 1'b0);
    @(negedge hclk);
    check("setclr_valid", 32'(err_valid), 32'h1);
    check("setclr_addr",  err_addr, 32'hBEEF_0000);
    tick();
    drive(32'h0, 2'b00, 1'b1, 1'b0);
    tick();
    drive(32'h0, 2'b00, 1'b1, 1'b1);
    tick();
    drive(32'h0, 2'b00, 1'b1, 1'b0);
    @(negedge hclk);
    check("clr_valid", 32'(err_valid), 32'h0);
    tick();
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0: a = {4'h0, 28'($urandom)};
        1: a = {4'h1, 28'($urandom)};
        2: a = {4'h2, 28'($urandom)};
        default: a = {4'($urandom_range(3, 15)), 28'($urandom)};
      endcase
      drive(a, 2'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      @(negedge hclk);
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
